pmem_line_responder: RTL and testbench



---
 rtl/pmem_line_responder.sv | 120 ++++++++++++
 tb/tb_pmem_line_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_responder.sv
// Line-granular physical memory responder below the cache.
// Fixed access delay, then eight 16-bit beats, then a one-cycle response.
module pmem_line_responder #(
  parameter int LINE_BITS = 6,
  parameter int DELAY     = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         busy,
  output logic         proto_err
);

  localparam int WORDS = 8 << LINE_BITS;
  localparam logic [3:0] DLY_LAST =
    (DELAY == 0) ? 4'd0 : 4'(DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic                 op_write;
  logic [LINE_BITS-1:0] line_idx;
  logic [127:0]         wbuf;
  logic [127:0]         rbuf;
  logic [2:0]           beat;
  logic [3:0]           dly;
  logic                 req;
  logic [LINE_BITS+2:0] word_addr;
  logic [15:0]          rd_word;
  logic [15:0]          wr_word;
  logic                 unused_addr;

  logic [15:0] mem [WORDS];

  assign req         = pmem_read | pmem_write;
  assign word_addr   = {line_idx, beat};
  assign rd_word     = mem[word_addr];
  assign wr_word     = wbuf[beat*16 +: 16];
  // Offset and alias bits of the address are deliberately dropped.
  assign unused_addr = ^pmem_address;

  assign pmem_resp  = (state == RESP);
  assign busy       = (state != IDLE);
  assign pmem_rdata = rbuf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (req)
          state_nxt = (DELAY == 0) ? XFER : WAIT;
      end
      WAIT: begin
        if (dly == DLY_LAST)
          state_nxt = XFER;
      end
      XFER: begin
        if (beat == 3'd7)
          state_nxt = RESP;
      end
      RESP: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_write  <= 1'b0;
      line_idx  <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      beat      <= '0;
      dly       <= '0;
      proto_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_write <= pmem_write;
            line_idx <= pmem_address[LINE_BITS+3:4];
            wbuf     <= pmem_wdata;
            beat     <= '0;
            dly      <= '0;
          end
          if (pmem_read && pmem_write)
            proto_err <= 1'b1;
        end
        WAIT: dly <= dly + 4'd1;
        XFER: begin
          beat <= beat + 3'd1;
          if (!op_write)
            rbuf[beat*16 +: 16] <= rd_word;
        end
        RESP: ;
      endcase
    end
  end

  // Array is never reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == XFER && op_write)
      mem[word_addr] <= wr_word;
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Randomized bench for pmem_line_responder.
// Line-level reference memory and cycle-counted latency checks.
module tb_pmem_line_responder;

  localparam int LB    = 6;
  localparam int DLY   = 4;
  localparam int NWORD = 8 << LB;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;
  logic         proto_err;

  logic [15:0] ref_mem [NWORD];

  int n_chk = 0;
  int n_err = 0;

  pmem_line_responder #(
    .LINE_BITS(LB),
    .DELAY(DLY)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata),
    .busy(busy),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [15:0] a);
    return int'(a[LB+3:4]);
  endfunction

  function automatic logic [127:0] ref_line(input logic [15:0] a);
    logic [127:0] l;
    for (int k = 0; k < 8; k++)
      l[k*16 +: 16] = ref_mem[line_of(a)*8 + k];
    return l;
  endfunction

  task automatic ref_write(input logic [15:0] a,
                           input logic [127:0] d,
                           input int nwords);
    for (int k = 0; k < nwords; k++)
      ref_mem[line_of(a)*8 + k] = d[k*16 +: 16];
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction; inputs are scrambled while busy to prove they are ignored.
  task automatic txn(input string tag,
                     input logic rd,
                     input logic wr,
                     input logic [15:0] a,
                     input logic [127:0] d);
    int lat;
    logic [127:0] exp;
    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = a;
    pmem_wdata   = d;
    exp = ref_line(a);
    if (wr) ref_write(a, d, 8);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        lat = i;
        break;
      end
      pmem_read    = (i <= DLY + 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      pmem_write   = (i <= DLY + 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      pmem_address = 16'($urandom);
      pmem_wdata   = rnd128();
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    chk({tag, "_lat"}, 128'(lat), 128'(DLY + 9));
    if (!wr && lat != 0)
      chk({tag, "_rdata"}, pmem_rdata, exp);
    @(negedge clk);
    chk({tag, "_resp_off"}, 128'(pmem_resp), 128'd0);
    chk({tag, "_idle"}, 128'(busy), 128'd0);
  endtask

  task automatic back_to_back();
    int t [2];
    int pulses;
    int extra;
    logic [127:0] exp;
    exp = ref_line(16'h0030);
    pulses = 0;
    extra = 0;
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 16'h0030;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (pmem_resp) begin
        t[pulses] = i;
        pulses++;
        chk("b2b_rdata", pmem_rdata, exp);
        if (pulses == 2) begin
          pmem_read = 1'b0;
          break;
        end
      end
    end
    pmem_read = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_resp) extra++;
    end
    chk("b2b_pulses", 128'(pulses + extra), 128'd2);
    if (pulses == 2) begin
      chk("b2b_first", 128'(t[0]), 128'(DLY + 9));
      chk("b2b_gap", 128'(t[1] - t[0]), 128'(DLY + 10));
    end
  endtask

  task automatic reset_mid_write(input logic [15:0] a,
                                 input logic [127:0] d);
    int seen;
    seen = 0;
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = a;
    pmem_wdata   = d;
    // Beat 3 is the fourth XFER cycle: DLY+4 cycles after sampling.
    for (int i = 1; i <= DLY + 4; i++) begin
      @(negedge clk);
      pmem_write = 1'b0;
      if (pmem_resp) seen++;
    end
    reset_n = 1'b0;
    ref_write(a, d, 3);
    #1;
    chk("rst_resp", 128'(pmem_resp), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_perr", 128'(proto_err), 128'd0);
    chk("rst_rdata", pmem_rdata, 128'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pmem_resp) seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pmem_resp) seen++;
    end
    chk("rst_no_resp", 128'(seen), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line3;
    logic [127:0] pat;
    logic [127:0] d;
    logic [15:0]  a;
    logic         op;
    reset_n      = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    for (int i = 0; i < NWORD; i++) begin
      ref_mem[i] = 16'($urandom);
      dut.mem[i] = ref_mem[i];
    end
    for (int k = 0; k < 8; k++) begin
      ref_mem[3*8 + k] = 16'((k + 1) * 16'h1111);
      dut.mem[3*8 + k] = ref_mem[3*8 + k];
    end
    repeat (3) @(negedge clk);
    chk("reset_resp", 128'(pmem_resp), 128'd0);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_perr", 128'(proto_err), 128'd0);
    chk("reset_rdata", pmem_rdata, 128'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_busy", 128'(busy), 128'd0);

    line3 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    txn("rd_line3", 1'b1, 1'b0, 16'h0030, '0);
    chk("rd_line3_const", pmem_rdata, line3);

    pat = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    txn("wr_50", 1'b0, 1'b1, 16'h0050, pat);
    txn("rd_5a", 1'b1, 1'b0, 16'h005A, '0);
    chk("rd_5a_const", pmem_rdata, pat);

    d = rnd128();
    txn("wr_alias", 1'b0, 1'b1, 16'h0400, d);
    txn("rd_alias", 1'b1, 1'b0, 16'h0000, '0);
    chk("rd_alias_const", pmem_rdata, d);

    back_to_back();

    for (int n = 0; n < 30; n++) begin
      op = 1'($urandom_range(0, 1));
      a  = 16'($urandom);
      d  = rnd128();
      txn("rand", ~op, op, a, d);
    end
    chk("perr_clear", 128'(proto_err), 128'd0);

    d = rnd128();
    txn("both", 1'b1, 1'b1, 16'h0070, d);
    chk("perr_set", 128'(proto_err), 128'd1);
    txn("rd_both", 1'b1, 1'b0, 16'h0070, '0);
    chk("rd_both_const", pmem_rdata, d);
    chk("perr_sticky", 128'(proto_err), 128'd1);

    reset_mid_write(16'h0090, rnd128());
    txn("rd_partial", 1'b1, 1'b0, 16'h0090, '0);
    chk("perr_after_rst", 128'(proto_err), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
